// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared constants, state encoding and reset coefficients for the FIR sequencer
package fir_ctrl_pkg;
    localparam int DW = 4;
    localparam int CW = 4;
    localparam int TAPS = 4;
    localparam int AW = $clog2(TAPS);
    localparam int OW = DW + CW + AW;
    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
    localparam logic [TAPS-1:0][CW-1:0] H_RST = {4'd4, 4'd3, 4'd2, 4'd1};
endpackage

// File: rtl/fir_tap_sequencer_if.sv
// fir_tap_sequencer_if: sample, result and coefficient-write signals of the FIR sequencer
interface fir_tap_sequencer_if;
    import fir_ctrl_pkg::*;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_ready;
    modport master (
        output in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fir_tap_mac.sv
// fir_tap_mac: registered multiply-accumulate with synchronous clear and enable
module fir_tap_mac
    import fir_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] coef,
    input  logic [DW-1:0] sample,
    output logic [OW-1:0] acc
);
    logic [CW+DW-1:0] prod;
    assign prod = {{DW{1'b0}}, coef} * {{CW{1'b0}}, sample};
    always_ff @(posedge clk or posedge rst)
        if (rst) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + {{(OW-CW-DW){1'b0}}, prod};
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR controller sharing one MAC across all taps
module fir_tap_sequencer
    import fir_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    fir_tap_sequencer_if.slave bus,
    output logic busy
);
    state_t state, state_nx;
    logic [TAPS-1:0][DW-1:0] dl;
    logic [TAPS-1:0][CW-1:0] coef;
    logic [AW:0] k;
    logic [OW-1:0] acc, out_data;
    logic accept, last;
    assign accept = state == IDLE && bus.in_valid && !flush;
    // k runs one past the last tap so the final product lands in acc before it is captured
    assign last = k == (AW+1)'(TAPS);
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_data = out_data;
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        state_nx = flush ? IDLE :
                   (state == IDLE && bus.in_valid) ? MAC :
                   (state == MAC && last) ? DONE :
                   (state == DONE && bus.out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dl <= '0;
            k <= '0;
            coef <= H_RST;
            out_data <= '0;
        end else begin
            if (flush) begin
                dl <= '0;
                k <= '0;
            end else if (accept) begin
                dl <= {dl[TAPS-2:0], bus.in_data};
                k <= '0;
            end else if (state == MAC && !last) k <= k + 1'b1;
            if (state == MAC && last && !flush) out_data <= acc;
            if (state == IDLE && bus.cfg_we) coef[bus.cfg_addr] <= bus.cfg_data;
        end
    fir_tap_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush || accept),
        .en     (state == MAC && !last),
        .coef   (coef[k[AW-1:0]]),
        .sample (dl[k[AW-1:0]]),
        .acc    (acc)
    );
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed-vector bench for the time-multiplexed FIR sequencer
module tb_fir_tap_sequencer;
    import fir_ctrl_pkg::*;
    logic clk, rst, flush, busy;
    int vectors = 0;
    int miscompares = 0;
    fir_tap_sequencer_if bus ();
    fir_tap_sequencer dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .busy(busy));
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [DW-1:0] d, output logic [OW-1:0] res, output int lat);
        int n = 0;
        while (!bus.in_ready && n < 50) begin tick(); n++; end
        bus.in_valid = 1;
        bus.in_data = d;
        tick();
        bus.in_valid = 0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin tick(); lat++; end
        res = bus.out_data;
        if (bus.out_ready) tick();
    endtask
    task automatic pulse_flush();
        flush = 1;
        tick();
        flush = 0;
    endtask
    task automatic test_reset();
        vectors += 4;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tick();
        rst = 0;
        tick();
    endtask
    task automatic test_impulse();
        logic [OW-1:0] r;
        int l;
        logic [OW-1:0] exp_v [5] = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd0};
        logic [DW-1:0] din [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        bus.out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            push(din[i], r, l);
            vectors += 2;
            if (r !== exp_v[i]) begin miscompares++; $display("FAIL impulse[%0d]: got %0d expected %0d", i, r, exp_v[i]); end
            if (l !== TAPS + 1) begin miscompares++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", i, l, TAPS + 1); end
        end
    endtask
    task automatic test_full_scale_default();
        logic [OW-1:0] r;
        int l;
        logic [OW-1:0] exp_v [4] = '{10'd15, 10'd45, 10'd90, 10'd150};
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            push(4'd15, r, l);
            vectors++;
            if (r !== exp_v[i]) begin miscompares++; $display("FAIL full_default[%0d]: got %0d expected %0d", i, r, exp_v[i]); end
        end
    endtask
    task automatic test_flush_mid_mac();
        logic [OW-1:0] r;
        int l;
        logic seen = 0;
        bus.in_valid = 1;
        bus.in_data = 4'd9;
        tick();
        bus.in_valid = 0;
        tick();
        pulse_flush();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle: busy got %b expected 0", busy); end
        for (int i = 0; i < 10; i++) begin
            seen = seen | bus.out_valid;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL flush_no_valid: out_valid seen %b expected 0", seen); end
        push(4'd1, r, l);
        vectors++;
        if (r !== 10'd1) begin miscompares++; $display("FAIL flush_cleared: got %0d expected 1", r); end
    endtask
    task automatic test_coef_max();
        logic [OW-1:0] r;
        int l;
        logic [OW-1:0] exp_v [4] = '{10'd225, 10'd450, 10'd675, 10'd900};
        bus.cfg_we = 1;
        bus.cfg_data = 4'd15;
        for (int i = 0; i < TAPS; i++) begin
            bus.cfg_addr = AW'(i);
            tick();
        end
        bus.cfg_we = 0;
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            push(4'd15, r, l);
            vectors++;
            if (r !== exp_v[i]) begin miscompares++; $display("FAIL coef_max[%0d]: got %0d expected %0d", i, r, exp_v[i]); end
        end
    endtask
    task automatic test_backpressure();
        logic [OW-1:0] r;
        int l;
        pulse_flush();
        bus.out_ready = 0;
        push(4'd1, r, l);
        vectors++;
        if (r !== 10'd15) begin miscompares++; $display("FAIL hold_result: got %0d expected 15", r); end
        bus.cfg_we = 1;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors += 3;
            if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            if (bus.out_data !== 10'd15) begin miscompares++; $display("FAIL hold_data[%0d]: got %0d expected 15", i, bus.out_data); end
            if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        bus.cfg_we = 0;
        bus.out_ready = 1;
        tick();
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL release_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_data !== 10'd15) begin miscompares++; $display("FAIL release_data_held: got %0d expected 15", bus.out_data); end
        pulse_flush();
        push(4'd1, r, l);
        vectors++;
        if (r !== 10'd15) begin miscompares++; $display("FAIL cfg_ignored: got %0d expected 15", r); end
    endtask
    task automatic test_reset_mid_mac();
        logic [OW-1:0] r;
        int l;
        bus.cfg_we = 1;
        bus.cfg_addr = '0;
        bus.cfg_data = 4'd7;
        tick();
        bus.cfg_we = 0;
        pulse_flush();
        bus.in_valid = 1;
        bus.in_data = 4'd1;
        tick();
        bus.in_valid = 0;
        tick();
        rst = 1;
        #1;
        vectors += 4;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got %0d expected 0", bus.out_data); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        tick();
        rst = 0;
        tick();
        push(4'd1, r, l);
        vectors += 2;
        if (r !== 10'd1) begin miscompares++; $display("FAIL rst_coef_default: got %0d expected 1", r); end
        if (l !== TAPS + 1) begin miscompares++; $display("FAIL rst_latency: got %0d expected %0d", l, TAPS + 1); end
    endtask
    initial begin
        rst = 1;
        flush = 0;
        bus.in_valid = 0;
        bus.in_data = '0;
        bus.cfg_we = 0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.out_ready = 1;
        #12;
        test_reset();
        test_impulse();
        test_full_scale_default();
        test_flush_mid_mac();
        test_coef_max();
        test_backpressure();
        test_reset_mid_mac();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
